// File: rtl/apb_master_pkg.sv
// apb_master_pkg: shared types and default sizing for the two-requester APB master.
package apb_master_pkg;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_RW_REGION = 8;
  localparam int DEF_TIMEOUT_CYCLES = 16;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  typedef struct packed {
    logic write;
    logic [DEF_RW_REGION-1:0] addr;
    logic [DEF_DATA_WIDTH-1:0] wdata;
  } xfer_t;
endpackage

// File: rtl/apb_rr_arbiter.sv
// apb_rr_arbiter: combinational 2-way round-robin, favouring the requester not granted last.
module apb_rr_arbiter (
  input  logic [1:0] i_req_valid,
  input  logic       i_last_grant,
  input  logic       i_enable,
  output logic [1:0] o_grant
);
  always_comb begin
    o_grant = !i_enable ? 2'b00 : (&i_req_valid) ? (i_last_grant ? 2'b01 : 2'b10) : i_req_valid;
  end
endmodule

// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter: arbitrates two requesters onto one APB bus and returns the
// completion (data or error, including pready timeout) to the granted requester.
module apb_master_arbiter
  import apb_master_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int RW_REGION = DEF_RW_REGION,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                    pclk,
  input  logic                    preset,
  input  logic [1:0]              req_valid,
  output logic [1:0]              req_ready,
  input  logic [1:0]              req_write,
  input  logic [2*RW_REGION-1:0]  req_addr,
  input  logic [2*DATA_WIDTH-1:0] req_wdata,
  output logic [1:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic [RW_REGION-1:0]    paddr,
  output logic                    pselx,
  output logic                    penable,
  output logic                    pwrite,
  output logic [DATA_WIDTH-1:0]   pwdata,
  input  logic [DATA_WIDTH-1:0]   prdata,
  input  logic                    pready,
  input  logic                    pslverr
);
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  state_t r_state, w_next;
  logic r_last, r_owner, r_psel, r_penable, r_pwrite, r_rsp_err;
  logic [CW-1:0] r_cnt;
  logic [RW_REGION-1:0] r_paddr;
  logic [DATA_WIDTH-1:0] r_pwdata, r_rsp_rdata;
  logic [1:0] r_rsp_valid, w_grant;
  logic w_gidx, w_done, w_tmo;
  apb_rr_arbiter u_arb (
    .i_req_valid (req_valid),
    .i_last_grant(r_last),
    .i_enable    (r_state == IDLE),
    .o_grant     (w_grant)
  );
  assign req_ready = w_grant;
  assign w_gidx = w_grant[1];
  assign w_done = (r_state == ACCESS) && pready;
  assign w_tmo = (r_state == ACCESS) && !pready && (r_cnt == CW'(TIMEOUT_CYCLES - 1));
  always_comb begin
    w_next = (r_state == IDLE) ? ((|req_valid) ? SETUP : IDLE) :
             (r_state == SETUP) ? ACCESS :
             (w_done || w_tmo) ? IDLE : ACCESS;
  end
  always_ff @(posedge pclk) begin
    if (preset) begin
      r_state <= IDLE;
      r_last <= 1'b1;
      r_owner <= 1'b0;
      r_cnt <= '0;
      r_psel <= 1'b0;
      r_penable <= 1'b0;
      r_pwrite <= 1'b0;
      r_paddr <= '0;
      r_pwdata <= '0;
      r_rsp_valid <= '0;
      r_rsp_err <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_state <= w_next;
      r_rsp_valid <= '0;
      r_rsp_err <= 1'b0;
      r_rsp_rdata <= '0;
      if (|w_grant) begin
        r_paddr <= w_gidx ? req_addr[2*RW_REGION-1:RW_REGION] : req_addr[RW_REGION-1:0];
        r_pwrite <= req_write[w_gidx];
        r_pwdata <= !req_write[w_gidx] ? '0 :
                    w_gidx ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdata[DATA_WIDTH-1:0];
        r_owner <= w_gidx;
        r_last <= w_gidx;
        r_psel <= 1'b1;
      end
      if (r_state == SETUP) begin
        r_penable <= 1'b1;
        r_cnt <= '0;
      end
      if (r_state == ACCESS && !pready) r_cnt <= r_cnt + 1'b1;
      // timeout reuses the normal completion path with a forced error and no data
      if (w_done || w_tmo) begin
        r_psel <= 1'b0;
        r_penable <= 1'b0;
        r_rsp_valid <= {r_owner, !r_owner};
        r_rsp_err <= w_tmo || pslverr;
        r_rsp_rdata <= (w_done && !r_pwrite) ? prdata : '0;
      end
    end
  end
  assign paddr = r_paddr;
  assign pselx = r_psel;
  assign penable = r_penable;
  assign pwrite = r_pwrite;
  assign pwdata = r_pwdata;
  assign rsp_valid = r_rsp_valid;
  assign rsp_err = r_rsp_err;
  assign rsp_rdata = r_rsp_rdata;
endmodule

// File: tb/tb_apb_master_arbiter.sv
// tb_apb_master_arbiter: directed vector table plus hand sequences for timeout,
// reset mid-transfer and round-robin fairness.
module tb_apb_master_arbiter;
  logic pclk = 0, preset = 1;
  logic [1:0] req_valid = 0, req_write = 0, req_ready, rsp_valid;
  logic [15:0] req_addr = {8'h24, 8'h10};
  logic [63:0] req_wdata = {32'hCAFEF00D, 32'hDEADBEEF};
  logic [31:0] rsp_rdata, pwdata, prdata = 0;
  logic rsp_err, pselx, penable, pwrite, pready = 0, pslverr = 0;
  logic [7:0] paddr;
  int tests = 0, fails = 0;

  apb_master_arbiter dut (
    .pclk(pclk), .preset(preset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .paddr(paddr), .pselx(pselx), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    logic [1:0] rv, rw; logic prdy, perr; logic [31:0] prd;
    logic [1:0] rdy; logic ps, pn; logic [7:0] pa; logic pw; logic [31:0] pwd;
    logic [1:0] rspv; logic er; logic [31:0] rd;
  } vec_t;
  vec_t v [16];

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h want %h", n, a, e);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic chk_idle_zero(input string n);
    chk({n, " pselx"}, 32'(pselx), 0);
    chk({n, " penable"}, 32'(penable), 0);
    chk({n, " paddr"}, 32'(paddr), 0);
    chk({n, " pwrite"}, 32'(pwrite), 0);
    chk({n, " pwdata"}, pwdata, 0);
    chk({n, " rsp_valid"}, 32'(rsp_valid), 0);
    chk({n, " rsp_err"}, 32'(rsp_err), 0);
    chk({n, " rsp_rdata"}, rsp_rdata, 0);
  endtask

  initial begin
    v[0]  = '{2'b01, 2'b01, 0, 0, 0,            2'b01, 1, 0, 8'h10, 1, 32'hDEADBEEF, 2'b00, 0, 0};
    v[1]  = '{2'b00, 2'b00, 0, 0, 0,            2'b00, 1, 1, 8'h10, 1, 32'hDEADBEEF, 2'b00, 0, 0};
    v[2]  = '{2'b00, 2'b00, 1, 0, 32'h11111111, 2'b00, 0, 0, 8'h10, 1, 32'hDEADBEEF, 2'b01, 0, 0};
    v[3]  = '{2'b10, 2'b00, 0, 0, 0,            2'b10, 1, 0, 8'h24, 0, 0, 2'b00, 0, 0};
    v[4]  = '{2'b00, 2'b00, 0, 0, 0,            2'b00, 1, 1, 8'h24, 0, 0, 2'b00, 0, 0};
    v[5]  = '{2'b00, 2'b00, 0, 0, 0,            2'b00, 1, 1, 8'h24, 0, 0, 2'b00, 0, 0};
    v[6]  = v[5];
    v[7]  = v[5];
    v[8]  = '{2'b00, 2'b00, 1, 0, 32'h12345678, 2'b00, 0, 0, 8'h24, 0, 0, 2'b10, 0, 32'h12345678};
    v[9]  = '{2'b01, 2'b00, 0, 0, 0,            2'b01, 1, 0, 8'h10, 0, 0, 2'b00, 0, 0};
    v[10] = '{2'b00, 2'b00, 0, 0, 0,            2'b00, 1, 1, 8'h10, 0, 0, 2'b00, 0, 0};
    v[11] = '{2'b00, 2'b00, 1, 1, 32'hAAAA5555, 2'b00, 0, 0, 8'h10, 0, 0, 2'b01, 1, 32'hAAAA5555};
    v[12] = '{2'b00, 2'b00, 1, 1, 32'hFFFFFFFF, 2'b00, 0, 0, 8'h10, 0, 0, 2'b00, 0, 0};
    v[13] = '{2'b10, 2'b10, 0, 0, 0,            2'b10, 1, 0, 8'h24, 1, 32'hCAFEF00D, 2'b00, 0, 0};
    v[14] = '{2'b00, 2'b00, 0, 0, 0,            2'b00, 1, 1, 8'h24, 1, 32'hCAFEF00D, 2'b00, 0, 0};
    v[15] = '{2'b00, 2'b00, 1, 0, 32'h55555555, 2'b00, 0, 0, 8'h24, 1, 32'hCAFEF00D, 2'b10, 0, 0};

    tick();
    tick();
    chk_idle_zero("reset");
    preset = 0;
    #1 chk("reset req_ready", 32'(req_ready), 0);

    for (int i = 0; i < 16; i++) begin
      req_valid = v[i].rv; req_write = v[i].rw; pready = v[i].prdy; pslverr = v[i].perr; prdata = v[i].prd;
      #1 chk($sformatf("v%0d req_ready", i), 32'(req_ready), 32'(v[i].rdy));
      tick();
      chk($sformatf("v%0d pselx", i), 32'(pselx), 32'(v[i].ps));
      chk($sformatf("v%0d penable", i), 32'(penable), 32'(v[i].pn));
      chk($sformatf("v%0d paddr", i), 32'(paddr), 32'(v[i].pa));
      chk($sformatf("v%0d pwrite", i), 32'(pwrite), 32'(v[i].pw));
      chk($sformatf("v%0d pwdata", i), pwdata, v[i].pwd);
      chk($sformatf("v%0d rsp_valid", i), 32'(rsp_valid), 32'(v[i].rspv));
      chk($sformatf("v%0d rsp_err", i), 32'(rsp_err), 32'(v[i].er));
      chk($sformatf("v%0d rsp_rdata", i), rsp_rdata, v[i].rd);
    end

    // timeout: read on req0 with pready stuck low
    req_valid = 2'b01; req_write = 0; pready = 0; pslverr = 0; prdata = 32'h99999999;
    tick();
    req_valid = 0;
    tick();
    chk("tmo enter access", 32'({pselx, penable}), 3);
    for (int k = 1; k < 16; k++) begin
      tick();
      chk($sformatf("tmo hold %0d", k), 32'({pselx, penable, rsp_valid}), 32'b11_00);
    end
    tick();
    chk("tmo pselx/penable", 32'({pselx, penable}), 0);
    chk("tmo rsp_valid", 32'(rsp_valid), 32'b01);
    chk("tmo rsp_err", 32'(rsp_err), 1);
    chk("tmo rsp_rdata", rsp_rdata, 0);

    // reset while req1 write sits in ACCESS with pready about to complete it
    req_valid = 2'b10; req_write = 2'b10; prdata = 0;
    #1 chk("rst req1 granted", 32'(req_ready), 32'b10);
    tick();
    req_valid = 0;
    tick();
    chk("rst in access", 32'({pselx, penable}), 3);
    preset = 1; pready = 1;
    tick();
    chk_idle_zero("mid reset");
    preset = 0;
    tick();
    chk("post reset rsp_valid", 32'(rsp_valid), 0);

    // round robin from reset: both always valid, grants 0,1,0,1
    req_valid = 2'b11; req_write = 0; pready = 1;
    for (int t = 0; t < 4; t++) begin
      #1 chk($sformatf("rr%0d grant", t), 32'(req_ready), (t % 2) ? 32'b10 : 32'b01);
      tick();
      chk($sformatf("rr%0d ready setup", t), 32'(req_ready), 0);
      chk($sformatf("rr%0d paddr", t), 32'(paddr), (t % 2) ? 32'h24 : 32'h10);
      tick();
      chk($sformatf("rr%0d ready access", t), 32'(req_ready), 0);
      tick();
      chk($sformatf("rr%0d rsp_valid", t), 32'(rsp_valid), (t % 2) ? 32'b10 : 32'b01);
    end
    req_valid = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
endmodule
